abr_ram_fifo_ctrl: RTL and testbench

ABR_RAM_FIFO_CTRL -- requirements
Module: abr_ram_fifo_ctrl

---
 rtl/abr_ram_fifo_ctrl.sv | 107 ++++++++++
 tb/tb_abr_ram_fifo_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abr_ram_fifo_ctrl.sv
// FIFO controller for an external 1R1W registered-read RAM with a 2-entry output stage.
// Define ABR_RAM_FIFO_HWM_EN to build the high-water-mark register.
module abr_ram_fifo_ctrl #(
  parameter int DEPTH      = 512,
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_waddr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic                  ram_re_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic [ADDR_WIDTH+1:0] count_o,
  output logic [ADDR_WIDTH+1:0] hwm_o
);

  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  inflight;
  logic [1:0]            stage_cnt;
  logic [DATA_WIDTH-1:0] stage0;
  logic [DATA_WIDTH-1:0] stage1;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;

  // ram_cnt never exceeds DEPTH, so its MSB alone flags a full RAM
  assign ram_cnt  = wptr - rptr;
  assign wready_o = ~ram_cnt[ADDR_WIDTH];
  assign push     = wvalid_i & wready_o & ~rst_i;
  assign rvalid_o = (stage_cnt != 2'd0);
  assign pop      = rvalid_o & rready_i & ~rst_i;
  assign rdata_o  = stage0;

  assign occ   = {1'b0, stage_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue = (ram_cnt != '0) & (occ < 3'd2) & ~rst_i;

  assign ram_we_o    = push;
  assign ram_waddr_o = wptr[ADDR_WIDTH-1:0];
  assign ram_wdata_o = wdata_i;
  assign ram_re_o    = issue;
  assign ram_raddr_o = rptr[ADDR_WIDTH-1:0];

  assign count_o = {1'b0, ram_cnt}
                 + {{(ADDR_WIDTH+1){1'b0}}, inflight}
                 + {{ADDR_WIDTH{1'b0}}, stage_cnt};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr      <= '0;
      rptr      <= '0;
      inflight  <= 1'b0;
      stage_cnt <= 2'd0;
      stage0    <= '0;
      stage1    <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (issue) rptr <= rptr + 1'b1;
      inflight <= issue;
      case ({pop, inflight})
        2'b11: begin
          if (stage_cnt == 2'd1) begin
            stage0 <= ram_rdata_i;
          end else begin
            stage0 <= stage1;
            stage1 <= ram_rdata_i;
          end
        end
        2'b10: begin
          stage0    <= stage1;
          stage_cnt <= stage_cnt - 2'd1;
        end
        2'b01: begin
          if (stage_cnt == 2'd0) stage0 <= ram_rdata_i;
          else stage1 <= ram_rdata_i;
          stage_cnt <= stage_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef ABR_RAM_FIFO_HWM_EN
  logic [ADDR_WIDTH+1:0] hwm;

  always_ff @(posedge clk_i) begin
    if (rst_i) hwm <= '0;
    else if (count_o > hwm) hwm <= count_o;
  end

  assign hwm_o = hwm;
`else
  assign hwm_o = '0;
`endif

endmodule

// File: tb/tb_abr_ram_fifo_ctrl.sv
// Directed bench for abr_ram_fifo_ctrl with a behavioural RAM and scoreboard.
// Expected hwm_o follows ABR_RAM_FIFO_HWM_EN.
module tb_abr_ram_fifo_ctrl;
  localparam int DEPTH = 512;
  localparam int DW    = 4;
  localparam int AW    = 9;
  localparam int CW    = AW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [DW-1:0] wdata = '0;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic [CW-1:0] count;
  logic [CW-1:0] hwm;

  int checks = 0;
  int errors = 0;
  int pops = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] sb [$];
  logic          stall = 1'b0;
  logic [DW-1:0] held;
  logic [DW-1:0] exp_d;

  always #5 clk = ~clk;

  abr_ram_fifo_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
    .ram_we_o(ram_we), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
    .ram_re_o(ram_re), .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata),
    .count_o(count), .hwm_o(hwm)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  // scoreboard, stall stability and read/write collision monitor
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      stall = 1'b0;
    end else begin
      if (ram_we && ram_re) begin
        checks++;
        if (ram_waddr == ram_raddr) begin
          errors++;
          $display("FAIL collision raddr %0h equals waddr %0h", ram_raddr, ram_waddr);
        end
      end
      if (stall && rvalid) begin
        checks++;
        if (rdata !== held) begin
          errors++;
          $display("FAIL stall_stable got %0h exp %0h", rdata, held);
        end
      end
      if (rvalid && rready) begin
        checks++;
        pops++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_order got %0h exp none", rdata);
        end else begin
          exp_d = sb.pop_front();
          if (rdata !== exp_d) begin
            errors++;
            $display("FAIL pop_order got %0h exp %0h", rdata, exp_d);
          end
        end
      end
      if (wvalid && wready) sb.push_back(wdata);
      stall = rvalid && !rready;
      held  = rdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wvalid = 1'b1; rready = 1'b1; wdata = 4'h3;
    step();
    step();
    wvalid = 1'b0; rready = 1'b0; rst = 1'b0;
    #1;
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL rst_wready got %b exp 1", wready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", rvalid); end
    checks++; if (count !== 11'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (hwm !== 11'd0) begin errors++; $display("FAIL rst_hwm got %0d exp 0", hwm); end
    checks++; if (rdata !== 4'h0) begin errors++; $display("FAIL rst_rdata got %0h exp 0", rdata); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b exp 0", ram_we); end
    checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL rst_ram_re got %b exp 0", ram_re); end
  endtask

  task automatic test_single();
    wvalid = 1'b1; wdata = 4'h5; rready = 1'b1;
    #1;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL single_we got %b exp 1", ram_we); end
    checks++; if (ram_waddr !== 9'd0) begin errors++; $display("FAIL single_waddr got %0h exp 0", ram_waddr); end
    checks++; if (ram_wdata !== 4'h5) begin errors++; $display("FAIL single_wdata got %0h exp 5", ram_wdata); end
    step();
    wvalid = 1'b0;
    checks++; if (count !== 11'd1) begin errors++; $display("FAIL single_c0 got %0d exp 1", count); end
    checks++; if (ram_re !== 1'b1) begin errors++; $display("FAIL single_re got %b exp 1", ram_re); end
    step();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL single_rv1 got %b exp 0", rvalid); end
    checks++; if (count !== 11'd1) begin errors++; $display("FAIL single_c1 got %0d exp 1", count); end
    step();
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL single_rv2 got %b exp 1", rvalid); end
    checks++; if (rdata !== 4'h5) begin errors++; $display("FAIL single_rd2 got %0h exp 5", rdata); end
    step();
    rready = 1'b0;
    checks++; if (count !== 11'd0) begin errors++; $display("FAIL single_c3 got %0d exp 0", count); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL single_rv3 got %b exp 0", rvalid); end
  endtask

  task automatic test_fill();
    int n = 0;
    int cyc = 0;
    logic acc;
    logic [CW-1:0] hexp;
    rready = 1'b0;
    while (n < 514 && cyc < 700) begin
      wvalid = 1'b1;
      wdata = n[3:0];
      acc = wready;
      step();
      if (acc) n++;
      cyc++;
    end
    wvalid = 1'b0;
    checks++; if (n != 514) begin errors++; $display("FAIL fill_budget got %0d exp 514", n); end
    step(); step(); step();
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL fill_wready got %b exp 0", wready); end
    checks++; if (count !== 11'd514) begin errors++; $display("FAIL fill_count got %0d exp 514", count); end
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL fill_rvalid got %b exp 1", rvalid); end
    checks++; if (rdata !== 4'h0) begin errors++; $display("FAIL fill_rdata got %0h exp 0", rdata); end
    checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL fill_re got %b exp 0", ram_re); end
`ifdef ABR_RAM_FIFO_HWM_EN
    hexp = 11'd514;
`else
    hexp = 11'd0;
`endif
    checks++; if (hwm !== hexp) begin errors++; $display("FAIL fill_hwm got %0d exp %0d", hwm, hexp); end
    wvalid = 1'b1; wdata = 4'hF;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL full_we got %b exp 0", ram_we); end
    step();
    wvalid = 1'b0;
    checks++; if (count !== 11'd514) begin errors++; $display("FAIL full_count got %0d exp 514", count); end
  endtask

  task automatic test_full_pop();
    int cyc = 0;
    wvalid = 1'b1; wdata = 4'hA; rready = 1'b1;
    #1;
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL fp_wready0 got %b exp 0", wready); end
    step();
    rready = 1'b0;
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL fp_wready1 got %b exp 1", wready); end
    checks++; if (count !== 11'd513) begin errors++; $display("FAIL fp_count1 got %0d exp 513", count); end
    step();
    wvalid = 1'b0;
    checks++; if (count !== 11'd514) begin errors++; $display("FAIL fp_count2 got %0d exp 514", count); end
    rready = 1'b1;
    while (count != 0 && cyc < 700) begin
      step();
      cyc++;
    end
    rready = 1'b0;
    checks++; if (count !== 11'd0) begin errors++; $display("FAIL fp_drain got %0d exp 0", count); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL fp_sb got %0d exp 0", sb.size()); end
  endtask

  task automatic test_stream();
    int pushed = 0;
    int cyc = 0;
    int p0 = pops;
    logic acc;
    rready = 1'b1;
    while (pushed < 1024 && cyc < 2000) begin
      wvalid = 1'b1;
      wdata = pushed[3:0];
      acc = wready;
      step();
      if (acc) pushed++;
      cyc++;
      if (cyc == 500) begin
        checks++;
        if (count !== 11'd3) begin errors++; $display("FAIL stream_steady got %0d exp 3", count); end
      end
    end
    wvalid = 1'b0;
    checks++; if (cyc != 1024) begin errors++; $display("FAIL stream_cycles got %0d exp 1024", cyc); end
    for (int i = 0; i < 4; i++) step();
    rready = 1'b0;
    checks++; if (pops - p0 != 1024) begin errors++; $display("FAIL stream_pops got %0d exp 1024", pops - p0); end
    checks++; if (count !== 11'd0) begin errors++; $display("FAIL stream_empty got %0d exp 0", count); end
  endtask

  task automatic test_backpressure();
    int pushed = 0;
    int cyc = 0;
    int p0 = pops;
    logic acc;
    while (pushed < 2000 && cyc < 20000) begin
      wvalid = ($urandom_range(0, 3) != 0);
      wdata = 4'($urandom);
      rready = $urandom_range(0, 1) == 1;
      acc = wvalid && wready;
      step();
      if (acc) pushed++;
      cyc++;
    end
    wvalid = 1'b0;
    rready = 1'b1;
    cyc = 0;
    while (count != 0 && cyc < 700) begin
      step();
      cyc++;
    end
    rready = 1'b0;
    checks++; if (pushed != 2000) begin errors++; $display("FAIL bp_budget got %0d exp 2000", pushed); end
    checks++; if (pops - p0 != 2000) begin errors++; $display("FAIL bp_pops got %0d exp 2000", pops - p0); end
    checks++; if (count !== 11'd0) begin errors++; $display("FAIL bp_empty got %0d exp 0", count); end
  endtask

  task automatic test_reset_mid();
    rready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wvalid = 1'b1;
      wdata = 4'(i + 1);
      step();
    end
    wvalid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (count !== 11'd7) begin errors++; $display("FAIL rm_count7 got %0d exp 7", count); end
    wvalid = 1'b1; wdata = 4'h8; rready = 1'b1;
    step();
    wvalid = 1'b0; rready = 1'b0;
    checks++; if (count !== 11'd7) begin errors++; $display("FAIL rm_inflight got %0d exp 7", count); end
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rm_rvalid got %b exp 1", rvalid); end
    rst = 1'b1; wvalid = 1'b1; rready = 1'b1;
    step();
    rst = 1'b0; wvalid = 1'b0; rready = 1'b0;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rm_rv0 got %b exp 0", rvalid); end
    checks++; if (count !== 11'd0) begin errors++; $display("FAIL rm_c0 got %0d exp 0", count); end
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL rm_wready got %b exp 1", wready); end
    step();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rm_rv1 got %b exp 0", rvalid); end
    checks++; if (count !== 11'd0) begin errors++; $display("FAIL rm_c1 got %0d exp 0", count); end
    checks++; if (hwm !== 11'd0) begin errors++; $display("FAIL rm_hwm got %0d exp 0", hwm); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_stream();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
